// File: rtl/csa_sweep_checker_if.sv
// Signal bundle between the sweep checker (master) and the adder under test
// plus whoever launches the sweep and reads its results (slave).
interface csa_sweep_checker_if #(
   parameter int WIDTH = 4
);
   // No valid/ready pair here: start is a level request that the checker samples
   // on every rising edge while idle or done; busy=1 means start is being ignored.
   logic                 start;
   logic [WIDTH-1:0]     dut_a;
   logic [WIDTH-1:0]     dut_b;
   logic                 dut_cin;
   logic [WIDTH-1:0]     dut_s;
   logic                 dut_cout;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [2*WIDTH+1:0]   err_count;
   logic                 first_fail_valid;
   logic [2*WIDTH:0]     first_fail_vec;

   modport master (
      input  start, dut_s, dut_cout,
      output dut_a, dut_b, dut_cin, busy, done, pass,
             err_count, first_fail_valid, first_fail_vec
   );

   modport slave (
      output start, dut_s, dut_cout,
      input  dut_a, dut_b, dut_cin, busy, done, pass,
             err_count, first_fail_valid, first_fail_vec
   );
endinterface

// File: rtl/csa_sweep_checker.sv
// On-chip exhaustive sweep of a WIDTH-bit adder with carry-in: drives every
// {cin,a,b}, waits SETTLE cycles, compares against a+b+cin and records mismatches.
module csa_sweep_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   csa_sweep_checker_if.master bus,
   output logic [1:0]          dbg_state
);
   localparam int VW = 2*WIDTH + 1;
   localparam int EW = VW + 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   logic [VW-1:0]  vec;
   logic [CW-1:0]  settle_cnt;
   logic           busy;
   logic           done;
   logic           pass;
   logic [EW-1:0]  err_count;
   logic           first_fail_valid;
   logic [VW-1:0]  first_fail_vec;
   logic [WIDTH:0] golden;
   logic           mismatch;

   // Golden sum built from the registered vector, i.e. exactly what the adder sees.
   always_comb begin
      golden   = {1'b0, vec[2*WIDTH-1:WIDTH]} + {1'b0, vec[WIDTH-1:0]}
               + {{WIDTH{1'b0}}, vec[VW-1]};
      mismatch = ({bus.dut_cout, bus.dut_s} != golden);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         vec              <= '0;
         settle_cnt       <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  vec              <= '0;
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  busy             <= 1'b1;
                  settle_cnt       <= CW'(SETTLE - 1);
                  state            <= WAIT;
               end
            end
            WAIT: begin
               if (settle_cnt == '0) state <= CHECK;
               else                  settle_cnt <= settle_cnt - CW'(1);
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + EW'(1);
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_vec   <= vec;
                  end
               end
               // The last vector stays on the adder pins after the sweep ends.
               if (&vec) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == '0);
               end else begin
                  vec        <= vec + VW'(1);
                  settle_cnt <= CW'(SETTLE - 1);
                  state      <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dut_cin          = vec[VW-1];
   assign bus.dut_a            = vec[2*WIDTH-1:WIDTH];
   assign bus.dut_b            = vec[WIDTH-1:0];
   assign bus.busy             = busy;
   assign bus.done             = done;
   assign bus.pass             = pass;
   assign bus.err_count        = err_count;
   assign bus.first_fail_valid = first_fail_valid;
   assign bus.first_fail_vec   = first_fail_vec;
   assign dbg_state            = state;
endmodule
